axi4_lite_sram_slave: RTL and testbench
=======================================

// Module: axi4_lite_sram_slave
// PURPOSE
//  AXI4-Lite responder (slave end) for a word-addressed on-chip SRAM. It sits behind the IFU/LSU bus arbiter.
//  Independent read and write channel FSMs serve requests with configurable latency, so latency-tolerance bugs in masters surface.
//  Out-of-range accesses return SLVERR.
// PARAMETERS
//  MEM_WORDS  1024            depth in 32-bit words (power of 2, >=2)
//  BASE_ADDR  32'h8000_0000   byte address of word 0
//  RD_LAT     1               cycles from AR handshake to first rvalid (>=1)
//  WR_LAT     1               cycles from AW+W capture to first bvalid (>=1)
// PORTS
//  clk      in   1   clock
//  rst      in   1   reset, asynchronous, active-high
//  awaddr   in  32   write address     | awvalid in 1 | awready out 1
//  wdata    in  32   write data        | wstrb in 4 byte enables | wvalid in 1 | wready out 1
//  bresp    out  2   write response    | bvalid out 1 | bready in 1
//  araddr   in  32   read address      | arvalid in 1 | arready out 1
//  rdata    out 32   read data         | rresp out 2  | rvalid out 1 | rready in 1
// BEHAVIOUR
//  Reset: all outputs 0 (readies, valids, rdata, resps); FSMs to IDLE; memory contents not reset.
//   Flop rdy_en resets 0 and sets on first clk edge after rst low; every *ready is gated by rdy_en.
//  Decode: idx = (addr-BASE_ADDR)>>2; addr[1:0] ignored; in range iff BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS.
//   Out of range: resp=2'b10 SLVERR, rdata=0, write dropped. In range: resp=2'b00 OKAY.
//  Read FSM R_IDLE -> R_WAIT -> R_RESP:
//   R_IDLE: arready=1; on arvalid&arready, latch araddr, load rcnt=RD_LAT-1; go R_WAIT (or straight to R_RESP if rcnt==0).
//   R_WAIT: decrement rcnt; at 0 sample mem[idx] into rdata and go R_RESP.
//   R_RESP: rvalid=1; rdata/rresp held stable until rready; on rvalid&rready, rvalid drops next cycle and FSM returns to R_IDLE.
//   New AR accepted no earlier than the cycle after the R handshake, so back-to-back reads take a minimum of RD_LAT+1 cycles each.
//  Write FSM W_IDLE -> W_WAIT -> W_RESP:
//   W_IDLE: awready=1 until AW captured; wready=1 until W captured; AW and W are accepted in either order or in the same cycle.
//   Once both are held, load wcnt=WR_LAT-1; go W_WAIT (or W_RESP if 0).
//   Memory commit: wstrb byte lanes written on the edge entering W_RESP; wstrb=0 means no change but still OKAY.
//   W_RESP: bvalid=1, bresp held until bready; on handshake, return to W_IDLE and clear AW/W captured flags.
//  Read/write same word, same edge: read samples the pre-write value; a write committed on an earlier edge is visible.
//  Master drops valid before handshake: not legal AXI; behaviour undefined, must not hang FSM beyond next valid.
//  rst asserted mid-transaction: transaction abandoned immediately; no B/R issued; partial write never committed.
// CONFIGURATION
//  AXI_SRAM_RAND_DELAY_EN defined:
//   Adds 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on rst), stepped every clk.
//   lfsr[1:0] (0..3) is added to rcnt/wcnt at each load, so the effective latency is LAT..LAT+3.
//   Read and write use lfsr[1:0] and lfsr[3:2] respectively.
//  Undefined: latency exactly RD_LAT / WR_LAT; no LFSR logic is instantiated.
// TESTING (macro undefined unless stated; RD_LAT=WR_LAT=1)
//  AW 0x8000_0010 + W 0xDEADBEEF strb 4'hF in the same cycle -> bvalid next cycle, bresp 0.
//   Then AR 0x8000_0010 -> rvalid 1 cycle after AR handshake, rdata 0xDEADBEEF, rresp 0.
//  W (0x11223344, strb 4'h3) two cycles before AW 0x8000_0010 -> awready still 1, wready 0 after W capture.
//   Readback gives 0xDEAD3344.
//  AR 0x9000_0000 (out of range) -> rresp 2'b10, rdata 0; write there -> bresp 2'b10, no array change.
//  rready held 0 for 5 cycles -> rvalid and rdata stable all 5 cycles; arready 0 until the cycle after the handshake.
//  RD_LAT=4: AR handshake at cycle N -> rvalid first high at N+4. rst pulsed at N+2 -> rvalid stays 0, arready 0 for 1 cycle after release.
//  AXI_SRAM_RAND_DELAY_EN, 256 reads -> every latency in [1,4], all four values observed, data correct.

Source files
------------

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave in front of a word-addressed on-chip SRAM, with independent read/write FSMs and configurable latency.
// Define AXI_SRAM_RAND_DELAY_EN to add 0..3 cycles of LFSR-driven jitter to every read and write.
module axi4_lite_sram_slave #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [31:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 4) + 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rdState_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wrState_e;

  logic [31:0] mem [MEM_WORDS];

  logic             rdyEn_q;
  rdState_e         rdState_q, rdState_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  wrState_e         wrState_q, wrState_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             awGot_q, awGot_d;
  logic             wGot_q, wGot_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [1:0]       bresp_q, bresp_d;

  logic [1:0]       rdExtra, wrExtra;
  logic [CNT_W-1:0] rdLoad, wrLoad;
  logic             rdSample, wrCommit, memWe;
  logic [31:0]      rdAddrSel, rdOff, wrAddrSel, wrOff, wrDataSel;
  logic [3:0]       wrStrbSel;
  logic             rdInRange, wrInRange;
  logic [IDX_W-1:0] rdIdx, wrIdx;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign rdExtra = lfsr_q[1:0];
  assign wrExtra = lfsr_q[3:2];
`else
  assign rdExtra = 2'd0;
  assign wrExtra = 2'd0;
`endif

  assign rdLoad = CNT_W'(RD_LAT - 1) + CNT_W'(rdExtra);
  assign wrLoad = CNT_W'(WR_LAT - 1) + CNT_W'(wrExtra);

  // Address decode uses the live bus value on the handshake cycle, the latched copy afterwards.
  assign rdAddrSel = (rdState_q == R_IDLE) ? araddr_i : araddr_q;
  assign rdOff     = (rdAddrSel - BASE_ADDR) >> 2;
  assign rdInRange = (rdAddrSel >= BASE_ADDR) && (rdOff < 32'(MEM_WORDS));
  assign rdIdx     = rdOff[IDX_W-1:0];

  assign wrAddrSel = awGot_q ? awaddr_q : awaddr_i;
  assign wrDataSel = wGot_q ? wdata_q : wdata_i;
  assign wrStrbSel = wGot_q ? wstrb_q : wstrb_i;
  assign wrOff     = (wrAddrSel - BASE_ADDR) >> 2;
  assign wrInRange = (wrAddrSel >= BASE_ADDR) && (wrOff < 32'(MEM_WORDS));
  assign wrIdx     = wrOff[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdyEn_q   <= 1'b0;
      rdState_q <= R_IDLE;
      rcnt_q    <= '0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      wrState_q <= W_IDLE;
      wcnt_q    <= '0;
      awGot_q   <= 1'b0;
      wGot_q    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
    end else begin
      rdyEn_q   <= 1'b1;
      rdState_q <= rdState_d;
      rcnt_q    <= rcnt_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      wrState_q <= wrState_d;
      wcnt_q    <= wcnt_d;
      awGot_q   <= awGot_d;
      wGot_q    <= wGot_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory is not reset; the array read happens in the same edge as a write, so reads see the old word.
  assign memWe = wrCommit && wrInRange;

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (wrStrbSel[b]) mem[wrIdx][8*b +: 8] <= wrDataSel[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdState_d = rdState_q;
    rcnt_d    = rcnt_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rdSample  = 1'b0;
    unique case (rdState_q)
      R_IDLE: begin
        if (arvalid_i && arready_o) begin
          araddr_d = araddr_i;
          rcnt_d   = rdLoad;
          if (rdLoad == '0) begin
            rdState_d = R_RESP;
            rdSample  = 1'b1;
          end else begin
            rdState_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        rcnt_d = rcnt_q - CNT_W'(1);
        if (rcnt_q == CNT_W'(1)) begin
          rdState_d = R_RESP;
          rdSample  = 1'b1;
        end
      end
      R_RESP: begin
        if (rready_i) rdState_d = R_IDLE;
      end
      default: rdState_d = R_IDLE;
    endcase
    if (rdSample) begin
      rdata_d = rdInRange ? mem[rdIdx] : 32'd0;
      rresp_d = rdInRange ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // AW and W are captured independently; the countdown starts once both are held.
  always_comb begin
    wrState_d = wrState_q;
    wcnt_d    = wcnt_q;
    awGot_d   = awGot_q;
    wGot_d    = wGot_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    wrCommit  = 1'b0;
    unique case (wrState_q)
      W_IDLE: begin
        if (awvalid_i && awready_o) begin
          awGot_d  = 1'b1;
          awaddr_d = awaddr_i;
        end
        if (wvalid_i && wready_o) begin
          wGot_d  = 1'b1;
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
        end
        if (awGot_d && wGot_d) begin
          wcnt_d = wrLoad;
          if (wrLoad == '0) begin
            wrState_d = W_RESP;
            wrCommit  = 1'b1;
          end else begin
            wrState_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        wcnt_d = wcnt_q - CNT_W'(1);
        if (wcnt_q == CNT_W'(1)) begin
          wrState_d = W_RESP;
          wrCommit  = 1'b1;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          wrState_d = W_IDLE;
          awGot_d   = 1'b0;
          wGot_d    = 1'b0;
        end
      end
      default: wrState_d = W_IDLE;
    endcase
    if (wrCommit) bresp_d = wrInRange ? RESP_OKAY : RESP_SLVERR;
  end

  always_comb begin
    arready_o = rdyEn_q && (rdState_q == R_IDLE);
    rvalid_o  = (rdState_q == R_RESP);
    rdata_o   = rdata_q;
    rresp_o   = rresp_q;
    awready_o = rdyEn_q && (wrState_q == W_IDLE) && !awGot_q;
    wready_o  = rdyEn_q && (wrState_q == W_IDLE) && !wGot_q;
    bvalid_o  = (wrState_q == W_RESP);
    bresp_o   = bresp_q;
  end

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Testbench for axi4_lite_sram_slave: two instances (fast and slow latency) checked against a word-array reference model.
// Latency expectations widen to LAT..LAT+3 when AXI_SRAM_RAND_DELAY_EN is defined.
module tb_axi4_lite_sram_slave;

  localparam int          WORDS = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LIMIT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic [31:0] araddr [2];
  logic [31:0] rdata  [2];
  logic [1:0]  bresp  [2];
  logic [1:0]  rresp  [2];
  logic awvalid [2];
  logic awready [2];
  logic wvalid  [2];
  logic wready  [2];
  logic bvalid  [2];
  logic bready  [2];
  logic arvalid [2];
  logic arready [2];
  logic rvalid  [2];
  logic rready  [2];

  logic [31:0] refMem [2][WORDS];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_lite_sram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .RD_LAT(1), .WR_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .awaddr_i(awaddr[0]), .awvalid_i(awvalid[0]), .awready_o(awready[0]),
    .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .wvalid_i(wvalid[0]), .wready_o(wready[0]),
    .bresp_o(bresp[0]), .bvalid_o(bvalid[0]), .bready_i(bready[0]),
    .araddr_i(araddr[0]), .arvalid_i(arvalid[0]), .arready_o(arready[0]),
    .rdata_o(rdata[0]), .rresp_o(rresp[0]), .rvalid_o(rvalid[0]), .rready_i(rready[0])
  );

  axi4_lite_sram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .RD_LAT(4), .WR_LAT(2)) dut1 (
    .clk(clk), .rst(rst),
    .awaddr_i(awaddr[1]), .awvalid_i(awvalid[1]), .awready_o(awready[1]),
    .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .wvalid_i(wvalid[1]), .wready_o(wready[1]),
    .bresp_o(bresp[1]), .bvalid_o(bvalid[1]), .bready_i(bready[1]),
    .araddr_i(araddr[1]), .arvalid_i(arvalid[1]), .arready_o(arready[1]),
    .rdata_o(rdata[1]), .rresp_o(rresp[1]), .rvalid_o(rvalid[1]), .rready_i(rready[1])
  );

  function automatic int rdLat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int wrLat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit inRng(input logic [31:0] a);
    longint unsigned la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * WORDS);
  endfunction

  function automatic int wordOf(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] expRead(input int d, input logic [31:0] a);
    return inRng(a) ? refMem[d][wordOf(a)] : 32'd0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkLat(input string tag, input int obs, input int base);
`ifdef AXI_SRAM_RAND_DELAY_EN
    checkOutput(tag, 32'(obs >= base && obs <= base + 3), 32'd1);
`else
    checkOutput(tag, obs, base);
`endif
  endtask

  // lead > 0: W is offered that many cycles before AW; lead < 0: AW leads.
  task automatic busWrite(input int d, input logic [31:0] a, input logic [31:0] dat,
                          input logic [3:0] s, input int lead);
    int awStart, wStart, t, lat;
    bit awDone, wDone, awHs, wHs;
    awStart = (lead > 0) ? lead : 0;
    wStart  = (lead < 0) ? -lead : 0;
    awaddr[d] = a; wdata[d] = dat; wstrb[d] = s; bready[d] = 1'b1;
    awDone = 0; wDone = 0; t = 0;
    while (!(awDone && wDone) && t < LIMIT) begin
      awvalid[d] = !awDone && (t >= awStart);
      wvalid[d]  = !wDone && (t >= wStart);
      awHs = awvalid[d] && awready[d];
      wHs  = wvalid[d] && wready[d];
      tick();
      t++;
      awDone = awDone || awHs;
      wDone  = wDone || wHs;
      if (wDone && !awDone) begin
        checkOutput("awreadyWhileWHeld", 32'(awready[d]), 32'd1);
        checkOutput("wreadyAfterWCapture", 32'(wready[d]), 32'd0);
      end
    end
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    checkOutput("wrHandshakeDone", 32'(awDone && wDone), 32'd1);
    lat = 1;
    while (!bvalid[d] && lat < LIMIT) begin
      tick();
      lat++;
    end
    checkOutput("bvalid", 32'(bvalid[d]), 32'd1);
    checkLat("wrLatency", lat, wrLat(d));
    checkOutput("bresp", 32'(bresp[d]), inRng(a) ? 32'd0 : 32'd2);
    if (inRng(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) refMem[d][wordOf(a)][8*b +: 8] = dat[8*b +: 8];
    end
    tick();
    bready[d] = 1'b0;
    checkOutput("bvalidDrop", 32'(bvalid[d]), 32'd0);
  endtask

  task automatic busRead(input int d, input logic [31:0] a, input int stall, output int lat);
    logic [31:0] expData;
    int t;
    expData = expRead(d, a);
    araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b0;
    t = 0;
    while (!arready[d] && t < LIMIT) begin
      tick();
      t++;
    end
    checkOutput("arready", 32'(arready[d]), 32'd1);
    tick();
    arvalid[d] = 1'b0;
    lat = 1;
    while (!rvalid[d] && lat < LIMIT) begin
      tick();
      lat++;
    end
    checkOutput("rvalid", 32'(rvalid[d]), 32'd1);
    checkLat("rdLatency", lat, rdLat(d));
    checkOutput("rdata", rdata[d], expData);
    checkOutput("rresp", 32'(rresp[d]), inRng(a) ? 32'd0 : 32'd2);
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput("rvalidHeld", 32'(rvalid[d]), 32'd1);
      checkOutput("rdataHeld", rdata[d], expData);
      checkOutput("arreadyBusy", 32'(arready[d]), 32'd0);
    end
    rready[d] = 1'b1;
    tick();
    rready[d] = 1'b0;
    checkOutput("rvalidDrop", 32'(rvalid[d]), 32'd0);
    checkOutput("arreadyAfterR", 32'(arready[d]), 32'd1);
  endtask

  task automatic applyStimulus(input int d, input int n);
    logic [31:0] a;
    int lat;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        busWrite(d, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)) - 2);
      else
        busRead(d, a, int'($urandom_range(0, 2)), lat);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] oldWord;
    int hist [4];
    for (int d = 0; d < 2; d++) begin
      awaddr[d] = '0; wdata[d] = '0; wstrb[d] = '0; araddr[d] = '0;
      awvalid[d] = 0; wvalid[d] = 0; bready[d] = 0; arvalid[d] = 0; rready[d] = 0;
    end

    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      checkOutput("rstAwready", 32'(awready[d]), 32'd0);
      checkOutput("rstWready", 32'(wready[d]), 32'd0);
      checkOutput("rstArready", 32'(arready[d]), 32'd0);
      checkOutput("rstBvalid", 32'(bvalid[d]), 32'd0);
      checkOutput("rstRvalid", 32'(rvalid[d]), 32'd0);
      checkOutput("rstRdata", rdata[d], 32'd0);
      checkOutput("rstResp", 32'({bresp[d], rresp[d]}), 32'd0);
    end
    rst = 1'b0;
    checkOutput("arreadyBeforeFirstEdge", 32'(arready[0]), 32'd0);
    tick();
    checkOutput("arreadyAfterFirstEdge", 32'(arready[0]), 32'd1);
    checkOutput("awreadyAfterFirstEdge", 32'(awready[0]), 32'd1);

    $display("[TB] filling memories");
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < WORDS; i++)
        busWrite(d, BASE + 32'(4 * i), $urandom, 4'hF, 0);

    busWrite(0, 32'h8000_0010, 32'hDEADBEEF, 4'hF, 0);
    busRead(0, 32'h8000_0010, 0, lat);
    busWrite(0, 32'h8000_0010, 32'h11223344, 4'h3, 2);
    busRead(0, 32'h8000_0010, 0, lat);
    checkOutput("partialStrobeWord", refMem[0][4], 32'hDEAD3344);
    busWrite(0, 32'h8000_0014, 32'h0BAD_F00D, 4'h0, -1);
    busRead(0, 32'h8000_0014, 0, lat);

    busRead(0, 32'h9000_0000, 0, lat);
    busWrite(0, 32'h9000_0000, 32'hCAFE_CAFE, 4'hF, 0);
    busRead(0, BASE, 0, lat);
    busWrite(0, BASE - 32'd4, 32'h1234_5678, 4'hF, 0);
    busRead(0, BASE - 32'd4, 0, lat);
    busWrite(0, BASE + 32'(4 * WORDS), 32'h8765_4321, 4'hF, 1);
    busRead(0, BASE + 32'(4 * WORDS), 0, lat);
    busRead(0, BASE + 32'(4 * (WORDS - 1)), 0, lat);
    busWrite(0, BASE + 32'(4 * (WORDS - 1)), 32'hA5A5_5A5A, 4'hF, 0);
    busRead(0, BASE + 32'(4 * (WORDS - 1)), 0, lat);
    busWrite(0, 32'h8000_0013, 32'h7777_8888, 4'hC, 0);
    busRead(0, 32'h8000_0010, 0, lat);

    busRead(0, 32'h8000_0010, 5, lat);

`ifndef AXI_SRAM_RAND_DELAY_EN
    $display("[TB] read and write of the same word on one edge");
    oldWord = refMem[0][8];
    awaddr[0] = BASE + 32'd32; wdata[0] = 32'h5555_AAAA; wstrb[0] = 4'hF;
    araddr[0] = BASE + 32'd32;
    awvalid[0] = 1; wvalid[0] = 1; arvalid[0] = 1; bready[0] = 0; rready[0] = 0;
    tick();
    awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0;
    checkOutput("sameEdgeRvalid", 32'(rvalid[0]), 32'd1);
    checkOutput("sameEdgeBvalid", 32'(bvalid[0]), 32'd1);
    checkOutput("sameEdgeOldData", rdata[0], oldWord);
    bready[0] = 1; rready[0] = 1;
    tick();
    bready[0] = 0; rready[0] = 0;
    refMem[0][8] = 32'h5555_AAAA;
    busRead(0, BASE + 32'd32, 0, lat);
`endif

    busWrite(1, BASE + 32'd12, 32'hFEED_FACE, 4'hF, 0);
    busRead(1, BASE + 32'd12, 0, lat);
    busWrite(1, BASE + 32'd12, 32'h0000_00AB, 4'h1, -2);
    busRead(1, BASE + 32'd12, 1, lat);

    $display("[TB] reset during a pending write");
    awaddr[1] = BASE + 32'd12; wdata[1] = 32'h1357_9BDF; wstrb[1] = 4'hF;
    awvalid[1] = 1; wvalid[1] = 1; bready[1] = 1;
    checkOutput("preRstWrReady", 32'(awready[1] && wready[1]), 32'd1);
    tick();
    awvalid[1] = 0; wvalid[1] = 0;
    rst = 1'b1;
    #1;
    checkOutput("rstWrBvalid", 32'(bvalid[1]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("postRstBvalid", 32'(bvalid[1]), 32'd0);
    bready[1] = 0;
    busRead(1, BASE + 32'd12, 0, lat);

    $display("[TB] reset during a pending read");
    araddr[1] = BASE + 32'd12; arvalid[1] = 1;
    checkOutput("preRstArready", 32'(arready[1]), 32'd1);
    tick();
    arvalid[1] = 0;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rstRdRvalid", 32'(rvalid[1]), 32'd0);
    checkOutput("rstRdArready", 32'(arready[1]), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("arreadyHeldAfterRelease", 32'(arready[1]), 32'd0);
    tick();
    checkOutput("arreadyReenabled", 32'(arready[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("rvalidAfterAbandon", 32'(rvalid[1]), 32'd0);
      tick();
    end

    $display("[TB] random traffic");
    applyStimulus(0, 150);
    applyStimulus(1, 100);

`ifdef AXI_SRAM_RAND_DELAY_EN
    $display("[TB] latency spread");
    for (int k = 0; k < 4; k++) hist[k] = 0;
    for (int i = 0; i < 256; i++) begin
      busRead(0, BASE + 32'(4 * (i % WORDS)), 0, lat);
      if (lat >= 1 && lat <= 4) hist[lat - 1]++;
    end
    for (int k = 0; k < 4; k++) checkOutput("latencyValueSeen", 32'(hist[k] > 0), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
